serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Sequencing controller for the team's shift-register serial adder datapath. It accepts operand pairs over a valid/ready handshake and drives the adder's load and shift controls for W cycles. It collects the serial sum bits into a parallel result and presents that result over a second valid/ready handshake. It sits between a parallel requester and one serial adder instance.

Parameters:
W, 4, operand and result width in bits; legal range is 2 to 32.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Rst  input  1  synchronous reset, active-high.
InValid  input  1  operand pair on InA/InB is valid.
InReady  output  1  controller can accept an operand pair.
InA  input  W  operand A.
InB  input  W  operand B.
OutValid  output  1  Result/Cout are valid.
OutReady  input  1  consumer accepts the result.
Result  output  W  sum, bits [W-1:0].
Cout  output  1  final carry; see Optional Feature.
AddLoad  output  1  to the datapath: load AddA/AddB and clear the carry on this edge.
AddShift  output  1  to the datapath: shift one bit and update the carry on this edge.
AddA  output  W  operand A to the datapath.
AddB  output  W  operand B to the datapath.
AddSum  input  1  from the datapath: combinational sum bit of the current LSBs plus carry.
AddCarry  input  1  from the datapath: current carry flip-flop value.

Behaviour:
- Clocking and reset:
  - Single clock domain, Clk.
  - Rst is synchronous, active-high, and has priority over every other input.
  - On Rst: state goes to IDLE; InReady=1 in the cycle after the reset edge.
  - Reset values: OutValid=0, AddLoad=0, AddShift=0, Result=0, Cout=0, AddA=0, AddB=0, bit counter=0.
  - Rst asserted mid-operation (LOAD, SHIFT or DONE) aborts the operation; the partial result is discarded and no OutValid pulse is produced.
- States:
  - IDLE: InReady=1. On InValid&InReady, latch InA to AddA and InB to AddB, then go to LOAD.
  - LOAD: exactly 1 cycle. AddLoad=1, InReady=0. Clear Result and counter. Go to SHIFT.
  - SHIFT: exactly W cycles. AddShift=1 each cycle. Each edge: Result <= {AddSum, Result[W-1:1]} (LSB-first fill) and counter increments. On the edge where counter==W-1, capture AddCarry into Cout's carry source and go to DONE.
  - DONE: OutValid=1. Result and Cout are held stable while OutValid=1 and OutReady=0. On OutValid&OutReady, go to IDLE.
- Timing:
  - Accept edge at cycle k. LOAD is cycle k+1; SHIFT covers cycles k+2 to k+W+1; OutValid=1 from cycle k+W+2.
  - Minimum issue interval is W+3 cycles.
- Output decoding:
  - InReady, OutValid, AddLoad and AddShift decode directly from the registered state; they have no combinational path from any input.
- Handshake rules:
  - InValid while not in IDLE is ignored; the operands are not captured.
  - InA and InB are sampled only on the accept edge; later changes have no effect.
  - AddA and AddB hold their values from the accept edge until the next accept.
- Boundary conditions:
  - Wrap-around: the sum is taken modulo 2^W; overflow is reported only via Cout.
  - OutReady asserted outside DONE is ignored.
  - There is no path from DONE directly to LOAD; IDLE always separates two operations.

Optional Feature:
Macro SERIAL_ADD_CTRL_COUT_EN.
- Defined: Cout = carry captured at the final SHIFT edge (the AddCarry value after bit W-1 is processed); Cout is valid with OutValid.
- Undefined: Cout is tied to 0 and no carry capture register is built.
- Result behaviour is identical in both builds.

Test Plan:
- W=4, COUT_EN defined, InA=1100, InB=0001, OutReady=1 -> OutValid rises exactly 6 cycles after the accept edge; Result=1101, Cout=0; AddShift is high for exactly 4 cycles.
- InA=1111, InB=0001 -> Result=0000, Cout=1. With the macro undefined, the same stimulus gives Result=0000, Cout=0.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> OutValid stays 1, Result is stable, InReady=0, and a new InValid is not accepted. Release OutReady -> IDLE follows, with InReady=1 the next cycle.
- Pulse Rst at the second SHIFT cycle of 1010+0101 -> next cycle is IDLE with OutValid=0, Result=0, AddShift=0. A fresh 0011+0011 then gives Result=0110.
- Back-to-back: InValid held high with two operand pairs (0111+0001, then 0010+0010) and OutReady=1 -> results 1000 then 0100. The second accept edge occurs 7 cycles after the first.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Sequencing controller for a shift-register serial adder datapath.
//   It accepts an operand pair over InValid/InReady and drives the adder with
//   one AddLoad cycle followed by W AddShift cycles. The LSB-first sum bits
//   are collected into Result, which is offered over OutValid/OutReady.
//
// Parameters
//   W         operand/result width, 2..32
//
// Ports
//   Clk, Rst            clock; synchronous active-high reset
//   InValid/InReady     operand handshake, InA/InB sampled on the accept edge
//   OutValid/OutReady   result handshake, Result/Cout held while OutValid=1
//   AddLoad/AddShift    datapath controls (registered state decodes)
//   AddA/AddB           operands to the datapath, held until the next accept
//   AddSum/AddCarry     datapath sum bit (combinational) and carry flop
//
// Build option
//   SERIAL_ADD_CTRL_COUT_EN  defined: Cout is the final carry out of bit W-1.
//                            undefined: Cout is tied to 0, no carry register.
module serial_add_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Result,
  output logic         Cout,
  output logic         AddLoad,
  output logic         AddShift,
  output logic [W-1:0] AddA,
  output logic [W-1:0] AddB,
  input  logic         AddSum,
  input  logic         AddCarry
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   add_a_q, add_a_d;
  logic [W-1:0]   add_b_q, add_b_d;

`ifdef SERIAL_ADD_CTRL_COUT_EN
  logic           cout_q, cout_d;
`else
  logic           unused_carry;
  assign unused_carry = AddCarry;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
`ifdef SERIAL_ADD_CTRL_COUT_EN
    cout_d   = cout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (InValid) begin
          add_a_d = InA;
          add_b_d = InB;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        result_d = '0;
        cnt_d    = '0;
`ifdef SERIAL_ADD_CTRL_COUT_EN
        cout_d   = 1'b0;
`endif
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        result_d = {AddSum, result_q[W-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_ADD_CTRL_COUT_EN
          // AddCarry is still the carry into bit W-1 here; the carry the
          // datapath flop takes on this edge is the majority of that carry and
          // the operand MSBs, which AddA/AddB still hold unshifted.
          cout_d = (add_a_q[W-1] & add_b_q[W-1]) |
                   (AddCarry & (add_a_q[W-1] ^ add_b_q[W-1]));
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
`ifdef SERIAL_ADD_CTRL_COUT_EN
      cout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
`ifdef SERIAL_ADD_CTRL_COUT_EN
      cout_q   <= cout_d;
`endif
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign AddLoad  = (state_q == S_LOAD);
  assign AddShift = (state_q == S_SHIFT);
  assign OutValid = (state_q == S_DONE);
  assign Result   = result_q;
  assign AddA     = add_a_q;
  assign AddB     = add_b_q;
`ifdef SERIAL_ADD_CTRL_COUT_EN
  assign Cout     = cout_q;
`else
  assign Cout     = 1'b0;
`endif

endmodule
